// File: rtl/bus_master_interface_if.sv
// Core-side request/response port plus the system-bus strobes of the bus master.
// The tri-state data bus is a separate inout port on the block itself.
interface bus_master_interface_if #(
   parameter int ADDR_BUS_WIDTH = 32,
   parameter int DATA_BUS_WIDTH = 8
) ();
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [ADDR_BUS_WIDTH-1:0] req_addr;
   logic [DATA_BUS_WIDTH-1:0] req_wdata;
   logic                      resp_valid;
   logic                      resp_error;
   logic [DATA_BUS_WIDTH-1:0] resp_rdata;
   logic [ADDR_BUS_WIDTH-1:0] addr_bus;
   logic                      wr_bus;
   logic                      rd_bus;
   logic                      fc_bus;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, fc_bus,
      output req_ready, resp_valid, resp_error, resp_rdata, addr_bus, wr_bus, rd_bus
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, fc_bus,
      input  req_ready, resp_valid, resp_error, resp_rdata, addr_bus, wr_bus, rd_bus
   );
endinterface

// File: rtl/bus_master_interface.sv
// Bus initiator: runs one read or write cycle per accepted request.
// Each cycle ends on a responder fc or on a timeout.
module bus_master_interface #(
   parameter int ADDR_BUS_WIDTH = 32,
   parameter int DATA_BUS_WIDTH = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   bus_master_interface_if.master    bus,
   inout  wire [DATA_BUS_WIDTH-1:0]  data_bus
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

   state_t                    r_state;
   logic [CNT_W-1:0]          r_cnt;
   logic [ADDR_BUS_WIDTH-1:0] r_addr;
   logic [DATA_BUS_WIDTH-1:0] r_wdata;
   logic                      r_wr;
   logic                      r_rd;
   logic                      r_resp_valid;
   logic                      r_resp_error;
   logic [DATA_BUS_WIDTH-1:0] r_resp_rdata;
   logic                      w_fc;

   // Only a definite 1 completes a cycle; Z or X from an unaddressed bus does not.
   assign w_fc = (bus.fc_bus == 1'b1);

   assign bus.req_ready  = (r_state == IDLE);
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_error = r_resp_error;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.addr_bus   = r_addr;
   assign bus.wr_bus     = r_wr;
   assign bus.rd_bus     = r_rd;

   // The write strobe is only ever high during a write ACCESS, so it doubles as drive enable.
   assign data_bus = r_wr ? r_wdata : 'z;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wr         <= 1'b0;
         r_rd         <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_error <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_state <= ACCESS;
                  r_addr  <= bus.req_addr;
                  r_wdata <= bus.req_wdata;
                  r_wr    <= bus.req_write;
                  r_rd    <= !bus.req_write;
                  r_cnt   <= '0;
               end
            end
            ACCESS: begin
               if (w_fc) begin
                  if (r_rd) begin
                     r_resp_rdata <= data_bus;
                  end
                  r_resp_valid <= 1'b1;
                  r_resp_error <= 1'b0;
                  r_wr         <= 1'b0;
                  r_rd         <= 1'b0;
                  r_state      <= RELEASE;
               end else if (r_cnt >= CNT_LAST) begin
                  r_resp_valid <= 1'b1;
                  r_resp_error <= 1'b1;
                  r_resp_rdata <= '0;
                  r_wr         <= 1'b0;
                  r_rd         <= 1'b0;
                  r_state      <= RELEASE;
               end else begin
                  // Bounded by CNT_LAST above, so the counter can never wrap.
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RELEASE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bus_master_interface.sv
// Randomized bench for bus_master_interface against a transaction-level model
// and a responder with a programmable fc delay.
module tb_bus_master_interface;
   localparam int AW = 32;
   localparam int DW = 8;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bus_master_interface_if #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) bus ();
   wire [DW-1:0] data_bus;

   bus_master_interface #(
      .ADDR_BUS_WIDTH(AW),
      .DATA_BUS_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .data_bus (data_bus)
   );

   // Responder at addresses 0..3: fc rises once the strobe has been high rsp_delay edges.
   logic [DW-1:0] rsp_mem [4] = '{8'h11, 8'h22, 8'h05, 8'h33};
   logic [3:0]    rsp_cnt = 4'd0;
   int            rsp_delay = 0;
   logic          rsp_hit;

   assign rsp_hit = (bus.addr_bus < 32'd4);

   always @(posedge clk) begin
      if ((bus.rd_bus || bus.wr_bus) && rsp_hit) rsp_cnt <= rsp_cnt + 4'd1;
      else                                       rsp_cnt <= 4'd0;
      if (bus.wr_bus && rsp_hit) rsp_mem[bus.addr_bus[1:0]] <= data_bus;
   end

   assign bus.fc_bus = (bus.rd_bus || bus.wr_bus) && rsp_hit && (int'(rsp_cnt) >= rsp_delay);
   assign data_bus   = (bus.rd_bus && rsp_hit) ? rsp_mem[bus.addr_bus[1:0]] : 'z;

   // Reference model state
   logic [DW-1:0] mdl_mem [4] = '{8'h11, 8'h22, 8'h05, 8'h33};
   logic [DW-1:0] mdl_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check_eq("req_ready_wait", 64'(bus.req_ready), 64'd1);
   endtask

   task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int delay);
      int            exp_access;
      int            cyc;
      logic          exp_err;
      logic [DW-1:0] exp_rdata;
      logic          hit;
      logic          bus_ok;
      hit = (addr < 32'd4);
      if (hit && delay <= TO - 1) begin
         exp_access = delay + 1;
         exp_err    = 1'b0;
         exp_rdata  = wr ? mdl_rdata : mdl_mem[addr[1:0]];
      end else begin
         exp_access = TO;
         exp_err    = 1'b1;
         exp_rdata  = '0;
      end
      if (hit && wr) mdl_mem[addr[1:0]] = wdata;
      mdl_rdata = exp_rdata;
      rsp_delay = delay;

      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      tick();
      bus.req_valid = 1'b0;

      cyc    = 1;
      bus_ok = 1'b1;
      while (bus.resp_valid !== 1'b1 && cyc < 40) begin
         if (bus.rd_bus !== !wr || bus.wr_bus !== wr || bus.addr_bus !== addr ||
             bus.req_ready !== 1'b0 || (wr && data_bus !== wdata))
            bus_ok = 1'b0;
         tick();
         cyc++;
      end
      check_eq("resp_seen",   64'(bus.resp_valid), 64'd1);
      check_eq("access_bus",  64'(bus_ok), 64'd1);
      check_eq("resp_cycle",  64'(cyc), 64'(exp_access + 1));
      check_eq("resp_error",  64'(bus.resp_error), 64'(exp_err));
      check_eq("resp_rdata",  64'(bus.resp_rdata), 64'(exp_rdata));
      check_eq("release_strobes", 64'({bus.rd_bus, bus.wr_bus, bus.req_ready}), 64'd0);
      $display("txn %0d %s addr=0x%0h wdata=0x%0h delay=%0d -> cycle=%0d err=%0d rdata=0x%0h",
               n_txn, wr ? "WR" : "RD", addr, wdata, delay, cyc, bus.resp_error, bus.resp_rdata);
      n_txn++;
      tick();
      check_eq("pulse_one_cycle", 64'({bus.resp_valid, bus.req_ready}), 64'b01);
   endtask

   // Write held straight into a read: the read is taken only once the block is back in IDLE.
   task automatic back_to_back(input logic [DW-1:0] wdata);
      int   cyc;
      int   gap;
      int   ready_hi;
      logic seen_rd;
      logic both;
      rsp_delay = 1;
      mdl_mem[1] = wdata;
      mdl_rdata  = wdata;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'd1;
      bus.req_wdata = wdata;
      tick();
      bus.req_write = 1'b0;
      bus.req_wdata = '0;
      cyc = 1; gap = 0; ready_hi = 0; seen_rd = 1'b0; both = 1'b0;
      while (!(bus.resp_valid === 1'b1 && seen_rd) && cyc < 40) begin
         if (bus.rd_bus && bus.wr_bus) both = 1'b1;
         if (bus.rd_bus === 1'b1) begin
            seen_rd = 1'b1;
            bus.req_valid = 1'b0;
         end else if (!seen_rd && bus.wr_bus !== 1'b1) begin
            gap++;
         end
         if (!seen_rd && bus.req_ready === 1'b1) ready_hi++;
         tick();
         cyc++;
      end
      bus.req_valid = 1'b0;
      // Two ACCESS for the write, RELEASE, the accepting IDLE, two ACCESS for the read.
      check_eq("b2b_resp_cycle", 64'(cyc), 64'd7);
      check_eq("b2b_idle_gap",   64'(gap), 64'd2);
      check_eq("b2b_ready_hi",   64'(ready_hi), 64'd1);
      check_eq("b2b_both_strobes", 64'(both), 64'd0);
      check_eq("b2b_rdata", 64'(bus.resp_rdata), 64'(wdata));
      check_eq("b2b_error", 64'(bus.resp_error), 64'd0);
      $display("txn %0d B2B WR+RD addr=0x1 wdata=0x%0h -> cycle=%0d gap=%0d rdata=0x%0h",
               n_txn, wdata, cyc, gap, bus.resp_rdata);
      n_txn++;
      tick();
   endtask

   task automatic reset_mid_write(input logic [DW-1:0] wdata);
      int   n_pulse;
      rsp_delay = 1;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'd3;
      bus.req_wdata = wdata;
      tick();
      bus.req_valid = 1'b0;
      check_eq("rst_pre_wr", 64'(bus.wr_bus), 64'd1);
      rst = 1'b1;
      tick();
      // The responder still latched the write on the reset edge while wr_bus was high.
      mdl_mem[3] = wdata;
      mdl_rdata  = '0;
      check_eq("rst_wr_bus",    64'(bus.wr_bus), 64'd0);
      check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
      check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check_eq("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
      rst = 1'b0;
      n_pulse = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.resp_valid === 1'b1) n_pulse++;
         tick();
      end
      check_eq("rst_no_resp", 64'(n_pulse), 64'd0);
      $display("txn %0d RST during WR addr=0x3 wdata=0x%0h", n_txn, wdata);
      n_txn++;
   endtask

   initial begin
      logic          r_wr;
      logic [AW-1:0] r_addr;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      rst = 1'b1;
      repeat (3) tick();
      check_eq("reset_ready", 64'(bus.req_ready), 64'd1);
      check_eq("reset_resp",  64'({bus.resp_valid, bus.resp_error}), 64'd0);
      check_eq("reset_rdata", 64'(bus.resp_rdata), 64'd0);
      check_eq("reset_addr",  64'(bus.addr_bus), 64'd0);
      check_eq("reset_strobes", 64'({bus.rd_bus, bus.wr_bus}), 64'd0);
      rst = 1'b0;
      tick();

      run_txn(1'b0, 32'd2, 8'h00, 0);
      run_txn(1'b1, 32'd0, 8'h01, 1);
      check_eq("rsp_reg0", 64'(rsp_mem[0]), 64'h01);
      run_txn(1'b0, 32'h100, 8'h00, 0);
      run_txn(1'b0, 32'd3, 8'h00, TO - 1);
      run_txn(1'b1, 32'd2, 8'hA5, TO);
      back_to_back(8'h5C);
      reset_mid_write(8'hC3);
      run_txn(1'b0, 32'd3, 8'h00, 0);

      for (int t = 0; t < 40; t++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_addr = ($urandom_range(0, 4) == 4) ? 32'h100 + 32'($urandom_range(0, 255))
                                              : 32'($urandom_range(0, 3));
         run_txn(r_wr, r_addr, 8'($urandom), int'($urandom_range(0, 9)));
      end
      for (int a = 0; a < 4; a++) begin
         check_eq("final_mem", 64'(rsp_mem[a]), 64'(mdl_mem[a]));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
